route_arbiter: RTL and testbench
================================

# route_arbiter

Output-port arbiter and buffer stage for the node/core router crossbar. It takes each input stream's one-hot routing vector from the router's "via" logic and the stream's valid/ready handshake. Each output port is shared among all inputs by round-robin arbitration, and the winner's word is registered into a one-deep output slot. It sits between the via computation and the output links, and makes output-port contention and link backpressure explicit.

## Interface
- `n_stream`, 5, number of input streams and output ports (`2*nw_dims+1` for a node router).
- `stream_width`, 132, word width: `data_width + net_width` (128 + 4).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `via_req`  in  n_stream*n_stream  bit `o*n_stream+i` set means input i targets output o.
- `in_valid`  in  n_stream  input i holds a word.
- `in_ready`  out  n_stream  input i is accepted this cycle.
- `in_stream`  in  n_stream*stream_width  word of input i at bits `[i*stream_width +: stream_width]`.
- `out_valid`  out  n_stream  output slot o is full.
- `out_ready`  in  n_stream  downstream link o accepts this cycle.
- `out_stream`  out  n_stream*stream_width  registered word of slot o, same packing as `in_stream`.
- `route_err`  out  1  sticky flag: some valid input presented a malformed via column.

## Operation
- **Request.** Input i requests output o when `in_valid[i] & via_req[o*n_stream+i]`.
- **Malformed via column.** A valid input with zero or more than one via bit set is malformed. It is never granted and sets `route_err`. `route_err` clears only on reset.
- **Slot availability.** Per output o, `avail[o] = ~out_valid[o] | out_ready[o]`. A slot that is being drained can reload in the same cycle.
- **Arbitration, per output.** Round-robin pointer `ptr[o]`, width `$clog2(n_stream)`.
  - The grant goes to the first requesting input at index ≥ `ptr[o]`, searching with wrap-around.
  - Grant occurs only if `avail[o]`.
- **Pointer update.** On a grant to input g, `ptr[o]` becomes g+1, or 0 if g = n_stream-1. The pointer is unchanged on cycles without a grant.
- **Ready generation.** `in_ready[i]` = 1 only if input i is granted its single target output. It is combinational from `in_valid`, `via_req`, `out_ready` and state. Upstream `in_valid` must not depend on `in_ready`.
- **Transfer.** A word is accepted on `in_valid[i] & in_ready[i]`. On the next edge, slot o loads `in_stream[i]` and `out_valid[o]` = 1.
- **Drain.** On `out_valid[o] & out_ready[o]` with no new grant, `out_valid[o]` → 0. `out_stream[o]` holds its last value.
- **Holding.** While `out_valid[o]` = 1 and `out_ready[o]` = 0, `out_stream[o]` is held stable.
- **Losing requests.** A losing or blocked input keeps its word and request. It cannot be dropped, and it is re-arbitrated every cycle.
- **Output independence.** Outputs are independent. Inputs targeting different outputs are granted in the same cycle.

## Timing
- **Reset (`rst_n` = 0, asynchronous):**
  - `out_valid` = 0, `out_stream` = 0, all `ptr` = 0, `route_err` = 0.
  - `in_ready` = 0 throughout reset.
- **Reset mid-operation.** Buffered words are discarded. The first grant after release uses `ptr` = 0.
- **Latency.** 1 cycle from the accept edge to `out_valid`.
- **Throughput.** One word per output per cycle with `out_ready` held at 1.
- **Full slot with `out_ready` = 0.** All `in_ready` for that output stay 0 and the pointer is frozen.
- **Simultaneous drain and load.** The slot stays valid with the new word, with no bubble.

## Test plan
- **Single transfer:** input 2 (data 0xA5), via bit for output 3, `out_ready` = 1.
  → `in_ready[2]` = 1 in the same cycle; `out_valid[3]` = 1 with 0xA5 the next cycle; all other outputs stay 0.
- **Contention:** inputs 0, 1 and 4 all target output 0 continuously, `ptr` = 0.
  → Grants follow 0, 1, 4, 0, 1, 4; output 0 carries one word per cycle.
- **Backpressure:** slot 1 full, `out_ready[1]` = 0 for 3 cycles, input 2 requests output 1.
  → `in_ready[2]` = 0 and `out_stream[1]` stable for 3 cycles; the cycle `out_ready[1]` = 1, `in_ready[2]` = 1 and the slot reloads with no bubble.
- **Malformed via:** input 1 valid with via bits for outputs 0 and 2.
  → `in_ready[1]` = 0; `route_err` = 1 next cycle and remains 1 after a well-formed stream.
- **Parallel routes:** input 0 targets output 4 and input 3 targets output 2 in the same cycle.
  → Both are granted; both slots are valid the next cycle.
- **Reset mid-stream:** `rst_n` low while slots 0 and 2 are full and `ptr[0]` = 3.
  → `out_valid` = 0 immediately (asynchronous); after release, contention on output 0 grants input 0 first.

Source files
------------

// File: rtl/route_arbiter_if.sv
// Bundle of the route_arbiter input/output stream handshakes.
// master drives requests and link readiness; slave is the arbiter itself.
interface route_arbiter_if #(
    parameter int unsigned n_stream     = 5,
    parameter int unsigned stream_width = 132
);
    logic [n_stream*n_stream-1:0]     via_req;
    logic [n_stream-1:0]              in_valid;
    logic [n_stream-1:0]              in_ready;
    logic [n_stream*stream_width-1:0] in_stream;
    logic [n_stream-1:0]              out_valid;
    logic [n_stream-1:0]              out_ready;
    logic [n_stream*stream_width-1:0] out_stream;
    logic                             route_err;

    modport master (
        output via_req, in_valid, in_stream, out_ready,
        input  in_ready, out_valid, out_stream, route_err
    );

    modport slave (
        input  via_req, in_valid, in_stream, out_ready,
        output in_ready, out_valid, out_stream, route_err
    );
endinterface

// File: rtl/route_arbiter.sv
// Per-output round-robin arbiter feeding a one-deep registered slot per output port.
// Inputs with a non-one-hot via column are never granted and latch route_err until reset.
module route_arbiter #(
    parameter int unsigned n_stream     = 5,
    parameter int unsigned stream_width = 132
) (
    input logic            clk,
    input logic            rst_n,
    route_arbiter_if.slave bus
);
    localparam int unsigned ptr_w = (n_stream > 1) ? $clog2(n_stream) : 1;

    logic [n_stream-1:0]     col     [n_stream];
    logic [n_stream-1:0]     col_ok;
    logic [n_stream-1:0]     req     [n_stream];
    logic [stream_width-1:0] in_word [n_stream];
    logic [n_stream-1:0]     avail;
    logic [n_stream-1:0]     gnt_any;
    logic [ptr_w-1:0]        gnt_idx [n_stream];
    logic [ptr_w-1:0]        ptr_d   [n_stream];
    logic [ptr_w-1:0]        ptr_q   [n_stream];
    logic [n_stream-1:0]     valid_q;
    logic [stream_width-1:0] data_q  [n_stream];
    logic                    err_q;

    // col[i] is input i's via column; req[o] is the request vector seen by output o.
    always_comb begin
        for (int i = 0; i < n_stream; i++) begin
            col[i] = '0;
            for (int o = 0; o < n_stream; o++) begin
                col[i][o] = bus.via_req[o*n_stream+i];
            end
            col_ok[i]  = $onehot(col[i]);
            in_word[i] = bus.in_stream[i*stream_width +: stream_width];
        end
        for (int o = 0; o < n_stream; o++) begin
            req[o] = '0;
            for (int i = 0; i < n_stream; i++) begin
                req[o][i] = bus.in_valid[i] & col[i][o] & col_ok[i];
            end
        end
        avail = ~valid_q | bus.out_ready;
    end

    always_comb begin : arb
        logic [2*n_stream-1:0] dbl;
        logic [ptr_w:0]        pos;
        for (int o = 0; o < n_stream; o++) begin
            // Rotate so the pointer position sits at bit 0; lowest set bit wins.
            dbl         = {req[o], req[o]} >> ptr_q[o];
            pos         = '0;
            gnt_any[o]  = 1'b0;
            for (int k = n_stream - 1; k >= 0; k--) begin
                if (dbl[k]) begin
                    gnt_any[o] = 1'b1;
                    pos        = {1'b0, ptr_q[o]} + (ptr_w+1)'(k);
                end
            end
            if (pos >= (ptr_w+1)'(n_stream)) begin
                pos = pos - (ptr_w+1)'(n_stream);
            end
            gnt_idx[o] = pos[ptr_w-1:0];
            gnt_any[o] = gnt_any[o] & avail[o] & rst_n;
            ptr_d[o]   = ptr_q[o];
            if (gnt_any[o]) begin
                ptr_d[o] = (gnt_idx[o] == ptr_w'(n_stream - 1)) ? '0 : gnt_idx[o] + 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int o = 0; o < n_stream; o++) begin
            for (int i = 0; i < n_stream; i++) begin
                if (gnt_any[o] && gnt_idx[o] == ptr_w'(i)) begin
                    bus.in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int o = 0; o < n_stream; o++) begin
                data_q[o] <= '0;
                ptr_q[o]  <= '0;
            end
        end else begin
            for (int o = 0; o < n_stream; o++) begin
                ptr_q[o] <= ptr_d[o];
                if (gnt_any[o]) begin
                    valid_q[o] <= 1'b1;
                    data_q[o]  <= in_word[gnt_idx[o]];
                end else if (bus.out_ready[o]) begin
                    valid_q[o] <= 1'b0;
                end
            end
            err_q <= err_q | (|(bus.in_valid & ~col_ok));
        end
    end

    always_comb begin
        bus.out_valid  = valid_q;
        bus.route_err  = err_q;
        bus.out_stream = '0;
        for (int o = 0; o < n_stream; o++) begin
            bus.out_stream[o*stream_width +: stream_width] = data_q[o];
        end
    end
endmodule

// File: tb/tb_route_arbiter.sv
// Bench for route_arbiter: table of per-cycle vectors plus hand-built backpressure and reset
// sequences; accepted words go through a scoreboard queue and are checked at the slot.
module tb_route_arbiter;
    localparam int unsigned n_stream     = 5;
    localparam int unsigned stream_width = 132;

    typedef struct {
        logic [4:0]  v;
        logic [24:0] via;
        logic [4:0]  ordy;
        logic [4:0]  rdy;
        logic        err;
    } vec_t;

    typedef struct {
        int           port;
        logic [131:0] word;
    } sb_t;

    logic clk;
    logic rst_n;
    route_arbiter_if #(.n_stream(n_stream), .stream_width(stream_width)) bus ();

    route_arbiter #(.n_stream(n_stream), .stream_width(stream_width)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           total = 0;
    int           bad   = 0;
    int           stamp = 0;
    sb_t          sb[$];
    logic [4:0]   exp_valid;
    logic [131:0] exp_word [5];
    vec_t         tbl [13];
    logic [24:0]  cont;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [24:0] vb(input int i, input int o);
        logic [24:0] one;
        one = 25'd1;
        return one << (o * 5 + i);
    endfunction

    function automatic logic [131:0] mkword(input int i, input int s);
        if (s == 0 && i == 2) return 132'hA5;
        return {4'(i), 32'(s), 32'hA5A5_0000 | 32'(i), 64'h0123_4567_89AB_CDEF ^ {32'(s), 32'(i)}};
    endfunction

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_valid = '0;
        for (int o = 0; o < 5; o++) exp_word[o] = '0;
        sb.delete();
    endtask

    task automatic run_cycle(input string nm, input logic [4:0] v, input logic [24:0] via,
                             input logic [4:0] ordy, input logic [4:0] rdy, input logic err);
        logic [4:0] loaded;
        sb_t        e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.via_req   = via;
        bus.out_ready = ordy;
        for (int i = 0; i < 5; i++) bus.in_stream[i*132 +: 132] = mkword(i, stamp);
        #1;
        chk({nm, " in_ready"}, 132'(bus.in_ready), 132'(rdy));
        loaded = '0;
        for (int i = 0; i < 5; i++) begin
            if (rdy[i]) begin
                for (int o = 0; o < 5; o++) begin
                    if (via[o*5+i]) begin
                        sb.push_back('{o, mkword(i, stamp)});
                        loaded[o] = 1'b1;
                    end
                end
            end
        end
        exp_valid = loaded | (exp_valid & ~ordy);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s load slot%0d", nm, e.port), bus.out_stream[e.port*132 +: 132],
                e.word);
            exp_word[e.port] = e.word;
        end
        chk({nm, " out_valid"}, 132'(bus.out_valid), 132'(exp_valid));
        for (int o = 0; o < 5; o++) begin
            chk($sformatf("%s hold slot%0d", nm, o), bus.out_stream[o*132 +: 132], exp_word[o]);
        end
        chk({nm, " route_err"}, 132'(bus.route_err), 132'(err));
        stamp++;
    endtask

    initial begin
        cont    = vb(0, 0) | vb(1, 0) | vb(4, 0);
        tbl[0]  = '{5'b00100, vb(2, 3), 5'b11111, 5'b00100, 1'b0};
        tbl[1]  = '{5'b10011, cont, 5'b11111, 5'b00001, 1'b0};
        tbl[2]  = '{5'b10011, cont, 5'b11111, 5'b00010, 1'b0};
        tbl[3]  = '{5'b10011, cont, 5'b11111, 5'b10000, 1'b0};
        tbl[4]  = '{5'b10011, cont, 5'b11111, 5'b00001, 1'b0};
        tbl[5]  = '{5'b10011, cont, 5'b11111, 5'b00010, 1'b0};
        tbl[6]  = '{5'b10011, cont, 5'b11111, 5'b10000, 1'b0};
        tbl[7]  = '{5'b01001, vb(0, 4) | vb(3, 2), 5'b11111, 5'b01001, 1'b0};
        tbl[8]  = '{5'b00010, vb(1, 0) | vb(1, 2), 5'b11111, 5'b00000, 1'b1};
        tbl[9]  = '{5'b00010, vb(1, 1), 5'b11111, 5'b00010, 1'b1};
        tbl[10] = '{5'b01010, vb(1, 2) | vb(3, 2), 5'b11111, 5'b00010, 1'b1};
        tbl[11] = '{5'b01000, vb(3, 2), 5'b11011, 5'b00000, 1'b1};
        tbl[12] = '{5'b00000, vb(1, 0) | vb(1, 2), 5'b11111, 5'b00000, 1'b1};

        // Reset state, with a would-be grant presented during reset.
        rst_n         = 1'b0;
        bus.in_valid  = 5'b00100;
        bus.via_req   = vb(2, 3);
        bus.out_ready = 5'b11111;
        bus.in_stream = '0;
        model_reset();
        #13;
        chk("reset in_ready", 132'(bus.in_ready), 132'd0);
        chk("reset out_valid", 132'(bus.out_valid), 132'd0);
        chk("reset out_stream", bus.out_stream[131:0], 132'd0);
        chk("reset route_err", 132'(bus.route_err), 132'd0);
        bus.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 13; r++) begin
            run_cycle($sformatf("row%0d", r), tbl[r].v, tbl[r].via, tbl[r].ordy, tbl[r].rdy,
                      tbl[r].err);
        end

        // Backpressure on output 1 for three cycles, then drain and reload together.
        run_cycle("bp_fill", 5'b00001, vb(0, 1), 5'b11111, 5'b00001, 1'b1);
        for (int c = 0; c < 3; c++) begin
            run_cycle($sformatf("bp_stall%0d", c), 5'b00100, vb(2, 1), 5'b11101, 5'b00000, 1'b1);
        end
        run_cycle("bp_release", 5'b00100, vb(2, 1), 5'b11111, 5'b00100, 1'b1);
        run_cycle("bp_drain", 5'b00000, '0, 5'b11111, 5'b00000, 1'b1);

        // Fill slots 0 and 2 (ptr[0] -> 3), hold them, then reset mid-stream.
        run_cycle("rs_fill", 5'b01100, vb(2, 0) | vb(3, 2), 5'b11111, 5'b01100, 1'b1);
        run_cycle("rs_hold", 5'b00000, '0, 5'b11010, 5'b00000, 1'b1);
        @(negedge clk);
        bus.in_valid  = 5'b10011;
        bus.via_req   = cont;
        bus.out_ready = 5'b11111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs out_valid", 132'(bus.out_valid), 132'd0);
        chk("rs out_stream0", bus.out_stream[0 +: 132], 132'd0);
        chk("rs out_stream2", bus.out_stream[264 +: 132], 132'd0);
        chk("rs route_err", 132'(bus.route_err), 132'd0);
        chk("rs in_ready", 132'(bus.in_ready), 132'd0);
        bus.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_cycle("rs_first", 5'b10011, cont, 5'b11111, 5'b00001, 1'b0);
        run_cycle("rs_second", 5'b10011, cont, 5'b11111, 5'b00010, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
